mem_port_arbiter: RTL

- Shares the single main-memory port between the instruction-cache controller (port I) and the data-cache controller (port D).
- Each controller issues a refill burst or a single write-through word.
- The arbiter grants the port round-robin, sequences the beats against the memory ready handshake and routes read data back.
- It sits between both cache controllers and the main-memory model; its stall-relevant outputs feed the controllers' stall logic.

---
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of client-side and memory-side signals around the main-memory port arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) ();
    // Port I (instruction-cache controller)
    logic              i_req;
    logic              i_we;
    logic              i_burst;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic              i_gnt;
    logic              i_rvalid;
    logic              i_done;
    // Port D (data-cache controller)
    logic              d_req;
    logic              d_we;
    logic              d_burst;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic              d_done;
    // Shared read data and memory side
    logic [DATA_W-1:0] rdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  i_req, i_we, i_burst, i_addr, i_wdata,
        input  d_req, d_we, d_burst, d_addr, d_wdata,
        input  mem_rdata, mem_ready,
        output i_gnt, i_rvalid, i_done,
        output d_gnt, d_rvalid, d_done,
        output rdata, mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_we, i_burst, i_addr, i_wdata,
        output d_req, d_we, d_burst, d_addr, d_wdata,
        output mem_rdata, mem_ready,
        input  i_gnt, i_rvalid, i_done,
        input  d_gnt, d_rvalid, d_done,
        input  rdata, mem_rd, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single main-memory port between the I and D cache
// controllers. Sequences single beats or aligned refill bursts against mem_ready and
// inserts a one-cycle release state between owners. State updates on the falling edge.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST_LEN = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CntW = $clog2(BURST_LEN);
    localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(BURST_LEN - 1);
    localparam logic [CntW-1:0] LastBurstBeat = CntW'(BURST_LEN - 1);
    localparam logic OwnerI = 1'b0;
    localparam logic OwnerD = 1'b1;

    typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic              burst_q, burst_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CntW-1:0]   beat_q, beat_d;

    logic              pick;
    logic              sel_we;
    logic              sel_burst;
    logic [ADDR_W-1:0] sel_addr;
    logic [CntW-1:0]   last_beat;

    // State register; reset abandons any in-flight transaction and favours port I next.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            owner_q <= OwnerI;
            last_q  <= OwnerD;
            we_q    <= 1'b0;
            burst_q <= 1'b0;
            base_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            burst_q <= burst_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
        end
    end

    // Arbitration, beat sequencing and all port outputs.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        we_d      = we_q;
        burst_d   = burst_q;
        base_d    = base_q;
        beat_d    = beat_q;
        pick      = OwnerI;
        sel_we    = 1'b0;
        sel_burst = 1'b0;
        sel_addr  = '0;
        last_beat = burst_q ? LastBurstBeat : '0;

        bus.i_gnt     = 1'b0;
        bus.d_gnt     = 1'b0;
        bus.i_rvalid  = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.i_done    = 1'b0;
        bus.d_done    = 1'b0;
        bus.rdata     = '0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        case (state_q)
            StIdle: begin
                if (bus.i_req || bus.d_req) begin
                    // On a tie the port that did not own the bus last time wins.
                    pick      = (bus.i_req && bus.d_req) ? ~last_q : ~bus.i_req;
                    sel_we    = (pick == OwnerD) ? bus.d_we    : bus.i_we;
                    sel_burst = (pick == OwnerD) ? bus.d_burst : bus.i_burst;
                    sel_addr  = (pick == OwnerD) ? bus.d_addr  : bus.i_addr;
                    owner_d   = pick;
                    we_d      = sel_we;
                    // Writes are always single beat; bursts are aligned refills.
                    burst_d   = ~sel_we & sel_burst;
                    base_d    = burst_d ? (sel_addr & AlignMask) : sel_addr;
                    beat_d    = '0;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                bus.i_gnt     = (owner_q == OwnerI);
                bus.d_gnt     = (owner_q == OwnerD);
                bus.mem_addr  = base_q + ADDR_W'(beat_q);
                bus.mem_rd    = ~we_q;
                bus.mem_wr    = we_q;
                bus.mem_wdata = (owner_q == OwnerD) ? bus.d_wdata : bus.i_wdata;
                if (bus.mem_ready) begin
                    if (!we_q) begin
                        bus.i_rvalid = (owner_q == OwnerI);
                        bus.d_rvalid = (owner_q == OwnerD);
                        bus.rdata    = bus.mem_rdata;
                    end
                    if (beat_q == last_beat) begin
                        bus.i_done = (owner_q == OwnerI);
                        bus.d_done = (owner_q == OwnerD);
                        state_d    = StRelease;
                    end else begin
                        beat_d = beat_q + CntW'(1);
                    end
                end
            end
            StRelease: begin
                last_d  = owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end
endmodule
